// File: rtl/ahfp_mult_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier between NREQ requesters.
// Optional contention counter enabled by defining AHFP_ARB_STALL_CNT_EN.
module ahfp_mult_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned LATENCY = 1,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_dataa,
    input  logic [32*NREQ-1:0]   req_datab,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_result,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          stall_count
);

    // Multiplier core: round-to-nearest-even, subnormal inputs and results flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic [7:0]        ea;
        logic [7:0]        eb;
        logic [47:0]       prod;
        logic signed [9:0] e_sum;
        logic [22:0]       man;
        logic              grd;
        logic              stk;
        logic [23:0]       rnd;
        logic              a_nan;
        logic              b_nan;
        logic              a_inf;
        logic              b_inf;
        sgn   = a[31] ^ b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);
        prod  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            man   = prod[46:24];
            grd   = prod[23];
            stk   = |prod[22:0];
            e_sum = e_sum + 10'sd1;
        end else begin
            man = prod[45:23];
            grd = prod[22];
            stk = |prod[21:0];
        end
        rnd = {1'b0, man} + {23'd0, grd & (stk | man[0])};
        if (rnd[23]) begin
            e_sum = e_sum + 10'sd1;
        end
        if (a_nan || b_nan) begin
            fp_mul = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            fp_mul = (ea == 8'd0 || eb == 8'd0) ? 32'h7FC0_0000 : {sgn, 8'hFF, 23'd0};
        end else if (ea == 8'd0 || eb == 8'd0) begin
            fp_mul = {sgn, 31'd0};
        end else if (e_sum >= 10'sd255) begin
            fp_mul = {sgn, 8'hFF, 23'd0};
        end else if (e_sum <= 10'sd0) begin
            fp_mul = {sgn, 31'd0};
        end else begin
            fp_mul = {sgn, e_sum[7:0], rnd[22:0]};
        end
    endfunction

    logic [IDW-1:0]  r_last_grant;
    logic [IDW-1:0]  w_winner;
    logic            w_found;
    logic [NREQ-1:0] w_ready;
    logic            w_xfer;

    logic            r_iv;
    logic [IDW-1:0]  r_iid;
    logic [31:0]     r_opa;
    logic [31:0]     r_opb;
    logic            r_mv;
    logic [IDW-1:0]  r_mid;
    logic [31:0]     r_mres;
    logic            r_pv   [LATENCY];
    logic [IDW-1:0]  r_pid  [LATENCY];
    logic [31:0]     r_pres [LATENCY];

    // Circular search starting one past the last winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[r_last_grant + IDW'(k + 1)]) begin
                w_found  = 1'b1;
                w_winner = r_last_grant + IDW'(k + 1);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (en && reset_n && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    assign w_xfer    = |w_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= IDW'(NREQ - 1);
            r_iv         <= 1'b0;
            r_iid        <= '0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_mv         <= 1'b0;
            r_mid        <= '0;
            r_mres       <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_pv[s]   <= 1'b0;
                r_pid[s]  <= '0;
                r_pres[s] <= '0;
            end
        end else begin
            r_iv <= w_xfer;
            if (w_xfer) begin
                r_iid        <= w_winner;
                r_opa        <= req_dataa[32*w_winner +: 32];
                r_opb        <= req_datab[32*w_winner +: 32];
                r_last_grant <= w_winner;
            end
            r_mv <= r_iv;
            if (r_iv) begin
                r_mid  <= r_iid;
                r_mres <= fp_mul(r_opa, r_opb);
            end
            // Payload only advances with a valid so the output holds between responses.
            r_pv[0] <= r_mv;
            if (r_mv) begin
                r_pid[0]  <= r_mid;
                r_pres[0] <= r_mres;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_pv[s] <= r_pv[s-1];
                if (r_pv[s-1]) begin
                    r_pid[s]  <= r_pid[s-1];
                    r_pres[s] <= r_pres[s-1];
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (r_pv[LATENCY-1]) begin
            rsp_valid[r_pid[LATENCY-1]] = 1'b1;
        end
    end

    assign rsp_result = r_pres[LATENCY-1];
    assign rsp_id     = r_pid[LATENCY-1];

`ifdef AHFP_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 16'd0;
        end else if (((req_valid & ~w_ready) != '0) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`else
    assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_ahfp_mult_arbiter.sv
// Directed bench for ahfp_mult_arbiter: vector table for single products plus
// hand-written sequences for rotation, enable, contention and reset.
module tb_ahfp_mult_arbiter;

    localparam int unsigned NREQ = 4;
`ifdef AHFP_ARB_STALL_CNT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          en;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_dataa;
    logic [127:0]  req_datab;
    logic [3:0]    rsp_valid;
    logic [31:0]   rsp_result;
    logic [1:0]    rsp_id;
    logic [15:0]   stall_count;

    int checks;
    int errors;

    ahfp_mult_arbiter #(
        .NREQ    (NREQ),
        .LATENCY (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_id      (rsp_id),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
        req_dataa[32*i +: 32] = a;
        req_datab[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        logic [3:0] oh;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        en        = 1'b1;
        req_valid = 4'h0;
        req_dataa = '0;
        req_datab = '0;

        vecs[0] = '{0, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};
        vecs[1] = '{2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[2] = '{1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000};
        vecs[3] = '{3, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000};
        vecs[4] = '{0, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
        vecs[5] = '{2, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};

        // Reset state, with requests present while reset is held.
        #1;
        req_valid = 4'hF;
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_result", rsp_result, 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_stall", 32'(stall_count), 32'h0);
        req_valid = 4'h0;
        step();
        reset_n = 1'b1;
        step();

        // All four requesters valid: grants rotate 0..3, responses follow two edges later.
        for (int i = 0; i < 4; i++) set_lane(i, 32'h3FC0_0000, 32'h4000_0000);
        req_valid = 4'hF;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                oh = 4'(1 << c);
                chk("rot_ready", 32'(req_ready), 32'(oh));
            end
            step();
            if (c < 4) req_valid[c] = 1'b0;
            if (c >= 2) begin
                oh = 4'(1 << (c - 2));
                chk("rot_rsp_valid", 32'(rsp_valid), 32'(oh));
                chk("rot_rsp_result", rsp_result, 32'h4040_0000);
                chk("rot_rsp_id", 32'(rsp_id), 32'(c - 2));
            end else begin
                chk("rot_rsp_idle", 32'(rsp_valid), 32'h0);
            end
        end

        // Single products from the vector table.
        for (int v = 0; v < 6; v++) begin
            set_lane(vecs[v].idx, vecs[v].a, vecs[v].b);
            oh = 4'(1 << vecs[v].idx);
            req_valid = oh;
            #1;
            chk("vec_ready", 32'(req_ready), 32'(oh));
            step();
            req_valid = 4'h0;
            #1;
            chk("vec_ready_drop", 32'(req_ready), 32'h0);
            chk("vec_rsp_early0", 32'(rsp_valid), 32'h0);
            step();
            chk("vec_rsp_early1", 32'(rsp_valid), 32'h0);
            step();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("vec_rsp_result", rsp_result, vecs[v].res);
            chk("vec_rsp_id", 32'(rsp_id), vecs[v].idx);
        end
        step();
        chk("hold_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("hold_rsp_result", rsp_result, vecs[5].res);
        chk("hold_rsp_id", 32'(rsp_id), vecs[5].idx);

        // Requesters 1 and 3 contend after a grant to 2.
        do_reset();
        req_valid = 4'b0100;
        #1;
        chk("alt_pre_ready", 32'(req_ready), 32'h4);
        step();
        chk("alt_pre_stall", 32'(stall_count), 32'h0);
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_ready", 32'(req_ready), (k % 2 == 0) ? 32'h8 : 32'h2);
            step();
            chk("alt_stall", 32'(stall_count), StallEn ? 32'(k + 1) : 32'h0);
        end
        req_valid = 4'h0;
        for (int k = 0; k < 3; k++) step();

        // en dropped after a transfer; in-flight product still returns.
        set_lane(0, 32'h4040_0000, 32'h4000_0000);
        set_lane(1, 32'h3FC0_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        #1;
        chk("en_ready", 32'(req_ready), 32'h1);
        step();
        en        = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("en_off_ready0", 32'(req_ready), 32'h0);
        step();
        chk("en_off_ready1", 32'(req_ready), 32'h0);
        chk("en_off_rsp0", 32'(rsp_valid), 32'h0);
        step();
        chk("en_off_ready2", 32'(req_ready), 32'h0);
        chk("en_off_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("en_off_rsp_result", rsp_result, 32'h40C0_0000);
        en = 1'b1;
        #1;
        chk("en_resume_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'h0;
        for (int k = 0; k < 3; k++) step();

        // Reset while a product is in flight.
        req_valid = 4'b0010;
        #1;
        chk("rst_pre_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'h0;
        step();
        chk("rst_inflight_rsp", 32'(rsp_valid), 32'h0);
        reset_n   = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp0", 32'(rsp_valid), 32'h0);
        chk("rst_stall", 32'(stall_count), 32'h0);
        step();
        chk("rst_rsp1", 32'(rsp_valid), 32'h0);
        step();
        req_valid = 4'h0;
        reset_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_post_rsp", 32'(rsp_valid), 32'h0);
        end
        req_valid = 4'hF;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahfp_mult_arbiter.md
# ahfp_mult_arbiter

Round-robin arbiter and pipeline sequencer that shares one `ahfp_mult` single-precision multiplier between `NREQ` requesters. Accepts at most one operand pair per cycle over a valid/ready handshake and registers the operands into the multiplier. It carries the requester ID through a fixed-depth result pipeline and returns each product as a one-cycle response tagged with that ID. It sits between the datapath clients and the single multiplier instance, which it owns internally.

## Interface
- `NREQ`, 4, number of requesters; power of two, 2..8.
- `LATENCY`, 1, result register stages after the multiplier; 1..4.
- `IDW`, $clog2(NREQ), requester ID width; derived, not overridden.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: grant enable. When low, no new requests are accepted; in-flight results still drain.
- `req_valid` in NREQ: bit i high means requester i presents operands.
- `req_ready` out NREQ: one-hot or zero; bit i high means requester i is accepted this cycle.
- `req_dataa` in 32*NREQ: requester i operand A at [32*i+31:32*i], IEEE-754 single.
- `req_datab` in 32*NREQ: requester i operand B, same packing.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse; bit i high means `rsp_result` belongs to requester i.
- `rsp_result` out 32: product from `ahfp_mult`.
- `rsp_id` out IDW: binary index of the requester that owns `rsp_result`.
- `stall_count` out 16: saturating contention counter (see Configuration).

## Operation
- Arbitration is combinational from `req_valid`, `en` and the pointer `last_grant`. The winner is the first i with `req_valid[i]=1`, searching circularly from `last_grant+1` (mod NREQ).
- `req_ready[winner]=1` only when `en=1`. All other bits are 0. No requester is ever granted twice in a row while another requester is waiting.
- Handshake: a transfer occurs when `req_valid[i] & req_ready[i]`. A requester holds valid and its data stable until that cycle; it may drop valid only after the transfer. `req_ready` may depend on `req_valid`.
- On a transfer edge the block:
  - registers `dataa`/`datab` of the winner into the operand registers that drive `ahfp_mult`;
  - sets issue-valid and issue-ID;
  - updates `last_grant` to the winner.
- With no transfer, issue-valid clears; operand registers hold their value.
- The multiplier output and tag pass through `LATENCY` register stages, with valid and ID shifted alongside. The final stage drives `rsp_valid` (decoded one-hot from ID, gated by valid), `rsp_result` and `rsp_id`.
- The pipeline never stalls, and responses have no backpressure. Throughput is one product per cycle.
- When no response is valid, `rsp_result` and `rsp_id` hold their last values. `rsp_valid` is 0.
- `en` falling does not cancel accepted operations.

## Timing
- Reset values:
  - `req_ready`=0 (no grant while `reset_n` low); `rsp_valid`=0; `rsp_result`=0; `rsp_id`=0; `stall_count`=0.
  - `last_grant`=NREQ-1, so requester 0 wins first.
  - All pipeline valid bits are 0.
- Latency: a transfer at edge E produces the response visible after edge E+LATENCY+1 (2 cycles for the default).
- Back-to-back transfers give back-to-back responses in acceptance order.
- If all requesters are valid, grants rotate 0,1,…,NREQ-1,0. A lone requester is granted every cycle.
- Reset mid-operation discards all in-flight products; no response is emitted for them.

## Configuration
- `AHFP_ARB_STALL_CNT_EN` defined:
  - `stall_count` increments by 1 on each edge where `(req_valid & ~req_ready) != 0`.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: `stall_count` is constant 0 and the counter logic is absent.

## Test plan
- Single request: req 0 sends 0x40400000 × 0x40000000 (3.0 × 2.0) at edge E -> `rsp_valid`=4'b0001, `rsp_result`=0x40C00000, `rsp_id`=0 after edge E+2; `req_ready[0]` high for one cycle.
- All four requesters hold valid, each with 0x3FC00000 × 0x40000000 (1.5 × 2.0) -> grants in order 0,1,2,3; four consecutive 0x40400000 responses with `rsp_id` 0,1,2,3.
- Requesters 1 and 3 hold valid, 3 is granted first after a prior grant to 2 -> alternation 3,1,3,1; `stall_count` (macro on) +1 per cycle.
- `en` dropped the cycle after a transfer -> no further `req_ready`; the in-flight response still arrives; `en` raised -> grants resume from `last_grant+1`.
- `reset_n` asserted one cycle after a transfer -> `rsp_valid` stays 0 throughout and after release; the first post-reset grant goes to requester 0.
- 0x00000000 × 0x00000000 from requester 2 -> `rsp_result`=0x00000000, `rsp_valid`=4'b0100.
